// File: rtl/pulse_event_counter_if.sv
// Event handshake bundle for pulse_event_counter.
// master: the counter presenting pending events; slave: the downstream consumer.
interface pulse_event_counter_if #(
  parameter int CNT_WIDTH = 4
) ();
  logic                 evt_valid;
  logic                 evt_ready;
  logic [CNT_WIDTH-1:0] pending_cnt;

  modport master (
    output evt_valid,
    output pending_cnt,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  pending_cnt,
    output evt_ready
  );
endinterface

// File: rtl/pulse_event_counter.sv
// pulse_event_counter: counts synchronized single-cycle pulses and presents
// them one at a time on a valid/ready handshake. Events arriving while the
// pending count is saturated are dropped and tallied, with a sticky overflow.
// Optional watchdog compiled in with macro PULSE_WATCHDOG_EN; without it the
// timeout output is tied low and TIMEOUT_CYCLES is unused.
module pulse_event_counter #(
  parameter int CNT_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk_dest,
  input  logic                          rst_dest,
  input  logic                          sig_pulse_dest,
  pulse_event_counter_if.master         evt_bus,
  output logic                          overflow,
  output logic [7:0]                    drop_cnt,
  input  logic                          overflow_clr,
  output logic                          timeout
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = {CNT_WIDTH{1'b1}};

  logic [CNT_WIDTH-1:0] pending_cnt_reg;
  logic [CNT_WIDTH-1:0] pending_cnt_next;
  logic                 overflow_reg;
  logic [7:0]           drop_cnt_reg;
  logic                 inc;
  logic                 dec;
  logic                 drop;

  // Per-cycle event terms; valid comes straight from the counter register.
  always_comb begin
    inc  = sig_pulse_dest;
    dec  = (pending_cnt_reg != '0) & evt_bus.evt_ready;
    drop = inc & ~dec & (pending_cnt_reg == MAX_CNT);
  end

  // Next pending count: +1 on a lone pulse, -1 on a lone handshake, hold otherwise.
  // A lone pulse at MAX is a drop, so the count holds instead of wrapping.
  always_comb begin
    pending_cnt_next = pending_cnt_reg;
    if (inc && !dec && !drop) begin
      pending_cnt_next = pending_cnt_reg + CNT_WIDTH'(1);
    end else if (!inc && dec) begin
      pending_cnt_next = pending_cnt_reg - CNT_WIDTH'(1);
    end
  end

  // Pending counter register.
  always_ff @(posedge clk_dest) begin
    if (rst_dest) begin
      pending_cnt_reg <= '0;
    end else begin
      pending_cnt_reg <= pending_cnt_next;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_dest) begin
    if (rst_dest) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end else if (overflow_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  // Saturating drop tally; a clear restarts it, counting a concurrent drop.
  always_ff @(posedge clk_dest) begin
    if (rst_dest) begin
      drop_cnt_reg <= 8'd0;
    end else if (overflow_clr) begin
      drop_cnt_reg <= drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt_reg != 8'd255)) begin
      drop_cnt_reg <= drop_cnt_reg + 8'd1;
    end
  end

  assign evt_bus.evt_valid   = (pending_cnt_reg != '0);
  assign evt_bus.pending_cnt = pending_cnt_reg;
  assign overflow            = overflow_reg;
  assign drop_cnt            = drop_cnt_reg;

`ifdef PULSE_WATCHDOG_EN
  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES);

  logic [TIMER_WIDTH-1:0] timer_reg;

  // Idle timer: restarts on every pulse, saturates at the threshold.
  always_ff @(posedge clk_dest) begin
    if (rst_dest || sig_pulse_dest) begin
      timer_reg <= '0;
    end else if (timer_reg != TIMER_LIMIT) begin
      timer_reg <= timer_reg + TIMER_WIDTH'(1);
    end
  end

  assign timeout = (timer_reg == TIMER_LIMIT);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/pulse_event_counter.md
# pulse_event_counter

Destination-domain consumer for synchronized single-cycle pulses. It counts pulses arriving from the slow-to-fast pulse synchronizer and presents them one at a time on a valid/ready handshake, so a downstream consumer that stalls loses no events. Pulses that arrive while the pending count is saturated are recorded as drops, with a sticky overflow flag. An optional watchdog reports when no pulse has arrived for a configurable number of cycles.

## Interface
Parameters:
- CNT_WIDTH, 4, width of pending-event counter; maximum pending count MAX = 2^CNT_WIDTH - 1
- TIMEOUT_CYCLES, 1024, watchdog threshold in clk_dest cycles; must be ≥ 2. Used only with the watchdog compiled in.

Ports:
- clk_dest  in  1  single clock (fast destination clock)
- rst_dest  in  1  reset; synchronous, active-high
- sig_pulse_dest  in  1  single-cycle event pulse from the synchronizer; one event per high cycle
- evt_valid  out  1  at least one event pending
- evt_ready  in  1  consumer accepts one event when high together with evt_valid
- pending_cnt  out  CNT_WIDTH  current number of pending events
- overflow  out  1  sticky; an event was dropped
- drop_cnt  out  8  number of dropped events, saturating at 255
- overflow_clr  in  1  clears overflow and drop_cnt
- timeout  out  1  watchdog flag; constant 0 when the watchdog is compiled out

## Operation
Per-cycle terms:
- inc = sig_pulse_dest
- dec = evt_valid & evt_ready
- drop = inc & ~dec & (pending_cnt == MAX)

Pending counter update:
- pending_cnt_next = pending_cnt + inc - dec, except when drop, in which case it holds at MAX.
- Simultaneous inc and dec leaves the count unchanged. This holds at MAX (no drop) and at 1.
- The count never wraps: it never goes below 0 and never goes above MAX.

Outputs and flags:
- evt_valid = (pending_cnt != 0), driven directly from the counter register; it has no combinational path from any input.
- evt_ready while evt_valid is low has no effect.
- overflow: set on drop, cleared by overflow_clr. If drop and overflow_clr occur in the same cycle, set wins and overflow = 1.
- drop_cnt: increments on drop and saturates at 255. overflow_clr loads 0, or loads 1 if drop occurs in the same cycle.

Reset:
- All outputs are 0 after reset: evt_valid = 0, pending_cnt = 0, overflow = 0, drop_cnt = 0, timeout = 0.
- Reset mid-operation discards all pending events; no event is presented after reset.

## Timing
- Every state element is registered on the rising edge of clk_dest.
- Pulse at edge N: pending_cnt increments and evt_valid rises, both visible after edge N+1. Event latency is 1 cycle.
- Handshake at edge N: pending_cnt decrements after edge N+1. If the count reaches 0, evt_valid is low from N+1.
- Back-to-back pulses on consecutive cycles are each counted, with no minimum pulse spacing.
- A pulse held high for k cycles counts as k events. The upstream synchronizer guarantees single-cycle pulses.
- overflow and drop_cnt update 1 cycle after the drop cycle.

## Configuration
Macro PULSE_WATCHDOG_EN.

When defined:
- A timer of width clog2(TIMEOUT_CYCLES+1) resets to 0 on rst_dest and on every sig_pulse_dest cycle.
- Otherwise the timer increments each cycle and saturates at TIMEOUT_CYCLES.
- timeout = (timer == TIMEOUT_CYCLES), driven directly from the timer register. It first asserts TIMEOUT_CYCLES cycles after reset release or after the last pulse.
- timeout holds until the next pulse and clears the cycle after that pulse.

When undefined:
- No timer logic is generated.
- timeout is tied to 0.
- TIMEOUT_CYCLES is ignored.

## Test plan
- Reset: assert rst_dest for 3 cycles while sig_pulse_dest toggles -> all outputs 0 during reset and on the first cycle after release.
- Single event: one pulse, evt_ready=1 -> evt_valid high exactly 1 cycle, starting 1 cycle after the pulse; pending_cnt goes 0→1→0.
- Stall and drain, CNT_WIDTH=4: evt_ready=0, 5 pulses -> pending_cnt=5; then evt_ready=1 -> exactly 5 handshakes, then evt_valid=0.
- Overflow, CNT_WIDTH=4:
  - 18 pulses with evt_ready=0 -> pending_cnt=15, drop_cnt=3, overflow=1.
  - Then pulse + handshake in the same cycle -> count stays 15, no new drop.
  - overflow_clr concurrent with a drop -> overflow=1, drop_cnt=1.
- Reset mid-operation: pending_cnt=7, pulse concurrent with rst_dest -> pending_cnt=0, evt_valid=0 next cycle.
- Watchdog (PULSE_WATCHDOG_EN, TIMEOUT_CYCLES=16):
  - No pulses -> timeout rises 16 cycles after reset release.
  - A pulse -> timeout falls next cycle and re-rises 16 cycles after that pulse.
  - With the macro undefined -> timeout stays 0 throughout.
